msrv32_hpm_counter_bank: RTL

//  Parametrised bank of NUM_HPM machine hardware-performance counters (mhpmcounter3.., mhpmevent3..), successor to the fixed

---
 rtl/msrv32_csr_pkg.sv | 31 +++
 rtl/msrv32_hpm_counter.sv | 105 ++++++++++
 rtl/msrv32_hpm_counter_bank.sv | 59 +++++
 3 files changed

// File: rtl/msrv32_csr_pkg.sv
// CSR address constants, CSR op encodings and event-register layout shared
// by the hardware-performance counter bank and its per-counter slices.
package msrv32_csr_pkg;

    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;

    localparam int EVT_OF_BIT = 31;
    localparam int EVT_IE_BIT = 30;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csrApply(input csr_op_e op, input logic [31:0] oldVal,
                                             input logic [31:0] wdata);
        logic [31:0] result;
        case (op)
            CSR_OP_WRITE: result = wdata;
            CSR_OP_SET:   result = oldVal | wdata;
            CSR_OP_CLEAR: result = oldVal & ~wdata;
            default:      result = oldVal;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/msrv32_hpm_counter.sv
// One hardware-performance counter slice: counter, event select, IE and
// sticky overflow flag, plus decode of its own three CSR addresses.
module msrv32_hpm_counter
    import msrv32_csr_pkg::*;
#(
    parameter int IDX        = 0,
    parameter int COUNTER_W  = 40,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [11:0]           i_addr,
    input  logic [1:0]            i_op,
    input  logic [31:0]           i_wdata,
    input  logic                  i_inhibit,
    input  logic [NUM_EVENTS-1:0] i_events,
    output logic [31:0]           o_rdata,
    output logic                  o_hit,
    output logic                  o_of,
    output logic                  o_irq
);

    localparam int SEL_W = $clog2(NUM_EVENTS + 1);
    localparam logic [11:0] ADDR_LO  = MHPMCOUNTER3  + 12'(IDX);
    localparam logic [11:0] ADDR_HI  = MHPMCOUNTER3H + 12'(IDX);
    localparam logic [11:0] ADDR_EVT = MHPMEVENT3    + 12'(IDX);
    localparam logic [31:0] EVT_MASK = 32'hC000_0000 | 32'((64'd1 << SEL_W) - 64'd1);

    logic [COUNTER_W-1:0]    r_cnt;
    logic [31:0]             r_evt;
    logic [63:0]             w_cnt64;
    logic                    w_hitLo;
    logic                    w_hitHi;
    logic                    w_hitEvt;
    logic                    w_wr;
    logic                    w_wrCnt;
    logic [31:0]             w_newLo;
    logic [31:0]             w_newHi;
    logic [63:0]             w_wrCnt64;
    logic [31:0]             w_newEvt;
    logic [(1<<SEL_W)-1:0]   w_evtPad;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_inc;
    logic                    w_wrap;

    // Zero-extended view makes bits above COUNTER_W read as 0 and drop on write.
    assign w_cnt64  = 64'(r_cnt);
    assign w_hitLo  = (i_addr == ADDR_LO);
    assign w_hitHi  = (i_addr == ADDR_HI);
    assign w_hitEvt = (i_addr == ADDR_EVT);
    assign o_hit    = w_hitLo | w_hitHi | w_hitEvt;
    assign w_wr     = i_wr_en & (i_op != 2'b00) & o_hit;
    assign w_wrCnt  = w_wr & (w_hitLo | w_hitHi);

    assign w_newLo   = csrApply(csr_op_e'(i_op), w_cnt64[31:0], i_wdata);
    assign w_newHi   = csrApply(csr_op_e'(i_op), w_cnt64[63:32], i_wdata);
    assign w_wrCnt64 = w_hitHi ? {w_newHi, w_cnt64[31:0]} : {w_cnt64[63:32], w_newLo};
    assign w_newEvt  = csrApply(csr_op_e'(i_op), r_evt, i_wdata) & EVT_MASK;

    // Code 0 and codes above NUM_EVENTS land on the zero padding.
    always_comb begin
        w_evtPad                 = '0;
        w_evtPad[NUM_EVENTS:1]   = i_events;
    end

    assign w_sel  = r_evt[SEL_W-1:0];
    assign w_inc  = w_evtPad[w_sel] & ~i_inhibit;
    assign w_wrap = w_inc & (r_cnt == '1) & ~w_wrCnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_evt <= '0;
        end else begin
            if (w_wrCnt) begin
                r_cnt <= COUNTER_W'(w_wrCnt64);
            end else if (w_inc) begin
                r_cnt <= r_cnt + COUNTER_W'(1);
            end
            if (w_wr && w_hitEvt) begin
                r_evt <= w_newEvt;
            end
            // Hardware overflow set takes priority over a same-edge software write.
            if (w_wrap) begin
                r_evt[EVT_OF_BIT] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (w_hitLo) begin
            o_rdata = w_cnt64[31:0];
        end else if (w_hitHi) begin
            o_rdata = w_cnt64[63:32];
        end else if (w_hitEvt) begin
            o_rdata = r_evt;
        end
    end

    assign o_of  = r_evt[EVT_OF_BIT];
    assign o_irq = r_evt[EVT_OF_BIT] & r_evt[EVT_IE_BIT];

endmodule

// File: rtl/msrv32_hpm_counter_bank.sv
// Bank of NUM_HPM machine performance counters; read data and hit are ORed
// across slices so the result can be merged into the CSR read mux.
module msrv32_hpm_counter_bank
    import msrv32_csr_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int COUNTER_W  = 40,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en_in,
    input  logic [11:0]           csr_addr_in,
    input  logic [1:0]            csr_op_in,
    input  logic [31:0]           csr_wdata_in,
    input  logic [31:0]           mcountinhibit_in,
    input  logic [NUM_EVENTS-1:0] events_in,
    output logic [31:0]           csr_rdata_out,
    output logic                  csr_hit_out,
    output logic [NUM_HPM-1:0]    ovf_status_out,
    output logic                  ovf_irq_out
);

    logic [31:0]        w_rdata [NUM_HPM];
    logic [NUM_HPM-1:0] w_hit;
    logic [NUM_HPM-1:0] w_irq;

    for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
        msrv32_hpm_counter #(
            .IDX        (k),
            .COUNTER_W  (COUNTER_W),
            .NUM_EVENTS (NUM_EVENTS)
        ) u_counter (
            .i_clk     (clk_in),
            .i_rst_n   (rst_in),
            .i_wr_en   (wr_en_in),
            .i_addr    (csr_addr_in),
            .i_op      (csr_op_in),
            .i_wdata   (csr_wdata_in),
            .i_inhibit (mcountinhibit_in[3+k]),
            .i_events  (events_in),
            .o_rdata   (w_rdata[k]),
            .o_hit     (w_hit[k]),
            .o_of      (ovf_status_out[k]),
            .o_irq     (w_irq[k])
        );
    end

    always_comb begin
        csr_rdata_out = '0;
        for (int k = 0; k < NUM_HPM; k++) begin
            csr_rdata_out = csr_rdata_out | (w_rdata[k] & {32{w_hit[k]}});
        end
    end

    assign csr_hit_out = |w_hit;
    assign ovf_irq_out = |w_irq;

endmodule
